// File: rtl/bitrev_frame_loader.sv
// Ping-pong input frame buffer: sequential sample writes, bit-reversed-order
// streaming reads through a valid/ready port with output holding register and skid.
module bitrev_frame_loader #(
    parameter int unsigned N     = 1024,
    parameter int unsigned WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_index,
    output logic                   out_last,
    output logic                   overflow
);

    localparam int unsigned     AW     = $clog2(N);
    localparam logic [AW-1:0]   K_LAST = AW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mem0 [N];
    logic [WIDTH-1:0]   r_mem1 [N];
    logic [WIDTH-1:0]   r_q0;
    logic [WIDTH-1:0]   r_q1;

    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic [AW-1:0]      r_wr_cnt;
    logic               r_rd_bank;

    logic [AW-1:0]      r_iss_k;
    logic               r_iss_done;
    logic               r_pend_v;
    logic [AW-1:0]      r_pend_k;

    logic               r_out_v;
    logic [WIDTH-1:0]   r_out_data;
    logic [AW-1:0]      r_out_k;
    logic               r_out_last;

    logic               r_skid_v;
    logic [WIDTH-1:0]   r_skid_data;
    logic [AW-1:0]      r_skid_k;

    logic               w_pop;
    logic               w_release;
    logic               w_accept;
    logic               w_issue;
    logic [AW-1:0]      w_iss_k;
    logic [AW-1:0]      w_rd_addr;
    logic [WIDTH-1:0]   w_pend_data;
    logic [1:0]         w_occ;

    function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            r[i] = k[AW-1-i];
        end
        return r;
    endfunction

    assign w_pop       = r_out_v && out_ready;
    assign w_release   = w_pop && r_out_last;
    assign w_accept    = !reset && in_valid &&
                         (!r_full[r_wr_bank] || (w_release && (r_rd_bank == r_wr_bank)));
    assign overflow    = !reset && in_valid && !w_accept;
    assign w_pend_data = r_rd_bank ? r_q1 : r_q0;
    assign w_rd_addr   = f_bitrev(w_iss_k);

    // Slots still occupied after this edge; a new read may only be issued if
    // its data is guaranteed a place (output register or skid) next cycle.
    assign w_occ = {1'b0, r_out_v} + {1'b0, r_skid_v} + {1'b0, r_pend_v} - {1'b0, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_iss_k     = r_iss_k;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_issue     = 1'b1;
                    w_iss_k     = '0;
                    w_state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                w_state_nxt = S_STREAM;
                if (!r_iss_done && (w_occ <= 2'd1)) begin
                    w_issue = 1'b1;
                end
            end
            S_STREAM: begin
                // With the other bank already full, the frame-end edge also
                // performs the idle-state read of k=0 so only one bubble appears.
                if (w_release) begin
                    if (r_full[~r_rd_bank]) begin
                        w_issue     = 1'b1;
                        w_iss_k     = '0;
                        w_state_nxt = S_PRIME;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!r_iss_done && (w_occ <= 2'd1)) begin
                    w_issue = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept && !r_wr_bank) begin
            r_mem0[r_wr_cnt] <= in_data;
        end
        r_q0 <= r_mem0[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (w_accept && r_wr_bank) begin
            r_mem1[r_wr_cnt] <= in_data;
        end
        r_q1 <= r_mem1[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_bank   <= 1'b0;
            r_iss_k     <= '0;
            r_iss_done  <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_k    <= '0;
            r_out_v     <= 1'b0;
            r_out_data  <= '0;
            r_out_k     <= '0;
            r_out_last  <= 1'b0;
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
            r_skid_k    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_accept) begin
                if (r_wr_cnt == K_LAST) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                end
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end

            if (w_issue) begin
                r_iss_k    <= w_iss_k + 1'b1;
                r_iss_done <= (w_iss_k == K_LAST);
                r_pend_k   <= w_iss_k;
            end
            r_pend_v <= w_issue;

            if (!r_out_v || w_pop) begin
                if (r_skid_v) begin
                    r_out_v     <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_k     <= r_skid_k;
                    r_out_last  <= (r_skid_k == K_LAST);
                    r_skid_v    <= r_pend_v;
                    r_skid_data <= w_pend_data;
                    r_skid_k    <= r_pend_k;
                end else if (r_pend_v) begin
                    r_out_v     <= 1'b1;
                    r_out_data  <= w_pend_data;
                    r_out_k     <= r_pend_k;
                    r_out_last  <= (r_pend_k == K_LAST);
                end else begin
                    r_out_v     <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end else if (r_pend_v) begin
                r_skid_v    <= 1'b1;
                r_skid_data <= w_pend_data;
                r_skid_k    <= r_pend_k;
            end
        end
    end

    assign out_valid = r_out_v;
    assign out_data  = r_out_data;
    assign out_index = r_out_k;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_bitrev_frame_loader.sv
// Self-checking bench for bitrev_frame_loader (N=8): table vectors plus a
// frame scoreboard checked on every output handshake.
module tb_bitrev_frame_loader;

    localparam int W = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    out_index;
    logic          out_last;
    logic          overflow;

    bitrev_frame_loader #(.N(8), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   k;
        logic         last;
    } exp_t;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp_d;
        logic [2:0]   exp_k;
        logic         exp_last;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          ovf_cnt = 0;
    exp_t        sb[$];
    vec_t        tv[8];
    logic [W-1:0] fb[8];
    int          fcnt = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Collects accepted samples; each completed frame queues its bit-reversed readout.
    task automatic record(input logic [W-1:0] d);
        fb[fcnt] = d;
        fcnt++;
        if (fcnt == 8) begin
            for (int k = 0; k < 8; k++) begin
                sb.push_back('{fb[rev3(3'(k))], 3'(k), (k == 7)});
            end
            fcnt = 0;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        fcnt = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            @(negedge clk);
        end
        check(name, sb.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {out_valid, out_last, out_index, out_data}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {out_index, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("out_word", {out_last, out_index, out_data}, {e.last, e.k, e.d});
                end
            end
            if (overflow) ovf_cnt <= ovf_cnt + 1;
            prev_stall <= out_valid && !out_ready;
            prev_word  <= {out_valid, out_last, out_index, out_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat[4];
        int   gap;
        bit   seen_last;
        bit   done;
        bit   found;

        tv[0] = '{12'd10, 12'd10, 3'd0, 1'b0};
        tv[1] = '{12'd11, 12'd14, 3'd1, 1'b0};
        tv[2] = '{12'd12, 12'd12, 3'd2, 1'b0};
        tv[3] = '{12'd13, 12'd16, 3'd3, 1'b0};
        tv[4] = '{12'd14, 12'd11, 3'd4, 1'b0};
        tv[5] = '{12'd15, 12'd15, 3'd5, 1'b0};
        tv[6] = '{12'd16, 12'd13, 3'd6, 1'b0};
        tv[7] = '{12'd17, 12'd17, 3'd7, 1'b1};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_overflow", overflow, 0);

        // Frame 10..17, ready high, with fill-latency check.
        do_reset();
        out_ready = 1'b1;
        ovf_cnt = 0;
        for (int i = 0; i < 8; i++) sb.push_back('{tv[i].exp_d, tv[i].exp_k, tv[i].exp_last});
        for (int i = 0; i < 8; i++) send(tv[i].din);
        @(negedge clk); check("lat_e0_valid", out_valid, 0);
        @(negedge clk); check("lat_e1_valid", out_valid, 0);
        @(negedge clk); check("lat_e2_valid", out_valid, 1);
        check("lat_e2_word", {out_index, out_data}, {3'd0, 12'd10});
        wait_drain("t1_drain");
        check("t1_overflow", ovf_cnt, 0);

        // Same frame, ready pattern 1,0,0,1.
        do_reset();
        for (int i = 0; i < 8; i++) sb.push_back('{tv[i].exp_d, tv[i].exp_k, tv[i].exp_last});
        fork
            begin
                for (int i = 0; i < 8; i++) send(tv[i].din);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = pat[c % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("t2_drain");

        // Both banks full with ready low; 8 extra samples drop.
        do_reset();
        ovf_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 16) record(W'(100 + i));
            send(W'(100 + i));
        end
        @(negedge clk);
        check("t3_overflow", ovf_cnt, 8);
        @(posedge clk); #1;
        out_ready = 1'b1;
        gap = 0; seen_last = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (seen_last && !out_valid) gap++;
            if (seen_last && out_valid) done = 1;
            if (out_valid && out_ready && out_last) seen_last = 1;
        end
        check("t3_bubble", gap, 1);
        wait_drain("t3_drain");

        // Ten frames back to back (one idle cycle each), ready high.
        do_reset();
        out_ready = 1'b1;
        ovf_cnt = 0;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 8; i++) begin
                in_data = W'($urandom_range(0, 4095));
                record(in_data);
                send(in_data);
            end
            @(posedge clk); #1;
        end
        wait_drain("t4_drain");
        check("t4_overflow", ovf_cnt, 0);

        // Reset after a partial frame discards it.
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(W'(i));
        do_reset();
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_quiet_after_reset", out_valid, 0);
        @(posedge clk); #1;
        for (int i = 20; i <= 27; i++) begin
            record(W'(i));
            send(W'(i));
        end
        wait_drain("t5_drain");

        // Write into a bank on the same edge its last output handshakes.
        do_reset();
        ovf_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            record(W'(200 + i));
            send(W'(200 + i));
        end
        out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (out_valid && out_index == 3'd7) found = 1;
        end
        check("t6_found_last", found, 1);
        in_valid = 1'b1;
        in_data  = W'(300);
        record(W'(300));
        @(negedge clk);
        check("t6_last_high", out_last, 1);
        check("t6_no_overflow", overflow, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            record(W'(300 + i));
            send(W'(300 + i));
        end
        wait_drain("t6_drain");
        check("t6_overflow", ovf_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
